// File: rtl/mfp_uart_dumper_if.sv
// AHB-Lite master-side signal bundle for the UART memory dumper.
interface mfp_uart_dumper_if;
  logic [31:0] dumper_HADDR;
  logic [2:0]  dumper_HBURST;
  logic        dumper_HMASTLOCK;
  logic [3:0]  dumper_HPROT;
  logic [2:0]  dumper_HSIZE;
  logic [1:0]  dumper_HTRANS;
  logic [31:0] dumper_HWDATA;
  logic        dumper_HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output dumper_HADDR, dumper_HBURST, dumper_HMASTLOCK, dumper_HPROT,
           dumper_HSIZE, dumper_HTRANS, dumper_HWDATA, dumper_HWRITE,
    input  HRDATA, HREADY, HRESP
  );
  modport slave (
    input  dumper_HADDR, dumper_HBURST, dumper_HMASTLOCK, dumper_HPROT,
           dumper_HSIZE, dumper_HTRANS, dumper_HWDATA, dumper_HWRITE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_uart_dumper.sv
// Read-only AHB-Lite master: reads a block of words and prints each one
// over an 8N1 UART as 8 uppercase hex digits followed by CR LF.
module mfp_uart_dumper #(
  parameter int BAUD_DIV  = 434,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  input  logic [31:0]          start_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  mfp_uart_dumper_if.master    ahb,
  output logic                 UART_TX,
  output logic                 dumper_Busy,
  output logic                 dumper_Done,
  output logic                 dumper_Error
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_SEND, S_FIN} state_t;
  state_t state, state_n;

  logic [31:0]          addr, word;
  logic [CNT_WIDTH-1:0] cnt;
  logic [BW-1:0]        baud;
  logic [3:0]           bit_idx, chr_idx;
  logic                 error;
  logic                 bit_end, frame_end, word_end;
  logic [3:0]           nib;
  logic [7:0]           chr;
  logic [15:0]          frame;

  assign bit_end   = (baud == BW'(BAUD_DIV - 1));
  assign frame_end = bit_end && (bit_idx == 4'd9);
  assign word_end  = frame_end && (chr_idx == 4'd9);

  // The shift word always holds the next nibble to print in its top bits.
  assign nib = word[31:28];
  always_comb begin
    chr = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    if (chr_idx == 4'd8) chr = 8'h0D;
    if (chr_idx == 4'd9) chr = 8'h0A;
  end

  // Bit 0 start, bits 1..8 data LSB first, bit 9 stop; upper padding unused.
  assign frame   = {6'h3F, 1'b1, chr, 1'b0};
  assign UART_TX = (state == S_SEND) ? frame[bit_idx] : 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = (word_count == '0) ? S_FIN : S_ADDR;
      S_ADDR: if (ahb.HREADY) state_n = S_DATA;
      S_DATA: if (ahb.HREADY) state_n = S_SEND;
      S_SEND: if (word_end) state_n = (cnt == CNT_WIDTH'(1)) ? S_FIN : S_ADDR;
      S_FIN:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr    <= '0;
      word    <= '0;
      cnt     <= '0;
      baud    <= '0;
      bit_idx <= '0;
      chr_idx <= '0;
      error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          addr  <= {start_addr[31:2], 2'b00};
          cnt   <= word_count;
          error <= 1'b0;
        end
        S_DATA: begin
          if (ahb.HRESP) error <= 1'b1;
          if (ahb.HREADY) begin
            word    <= ahb.HRDATA;
            baud    <= '0;
            bit_idx <= '0;
            chr_idx <= '0;
          end
        end
        S_SEND: begin
          if (!bit_end) begin
            baud <= baud + BW'(1);
          end else begin
            baud <= '0;
            if (bit_idx != 4'd9) begin
              bit_idx <= bit_idx + 4'd1;
            end else begin
              bit_idx <= '0;
              word    <= {word[27:0], 4'h0};
              if (chr_idx == 4'd9) begin
                addr <= addr + 32'd4;
                cnt  <= cnt - CNT_WIDTH'(1);
              end else begin
                chr_idx <= chr_idx + 4'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ahb.dumper_HADDR     = addr;
  assign ahb.dumper_HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign ahb.dumper_HBURST    = 3'b000;
  assign ahb.dumper_HMASTLOCK = 1'b0;
  assign ahb.dumper_HPROT     = 4'b0011;
  assign ahb.dumper_HSIZE     = 3'b010;
  assign ahb.dumper_HWDATA    = 32'd0;
  assign ahb.dumper_HWRITE    = 1'b0;

  assign dumper_Busy  = (state == S_ADDR) || (state == S_DATA) || (state == S_SEND);
  assign dumper_Done  = (state == S_FIN);
  assign dumper_Error = error;
endmodule

// File: tb/tb_mfp_uart_dumper.sv
// Scoreboard bench for mfp_uart_dumper: expected reads and UART bytes are
// queued at start time; bus and serial monitors pop and compare.
module tb_mfp_uart_dumper;
  localparam int BAUD = 8;
  localparam int CW   = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   start_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          UART_TX, busy, done, err;

  mfp_uart_dumper_if bus();

  mfp_uart_dumper #(.BAUD_DIV(BAUD), .CNT_WIDTH(CW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .start_addr(start_addr),
    .word_count(word_count), .ahb(bus), .UART_TX(UART_TX),
    .dumper_Busy(busy), .dumper_Done(done), .dumper_Error(err)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [31:0] exp_addr[$];
  logic [7:0]  exp_byte[$];
  logic [31:0] mem[logic [31:0]];

  int          aw_n = 0, dw_n = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: each word becomes its hex text, MSB nibble first, then CR LF.
  task automatic expect_dump(input logic [31:0] a, input int n);
    logic [31:0] x;
    int nb;
    x = {a[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      if (!mem.exists(x)) mem[x] = $urandom;
      exp_addr.push_back(x);
      for (int k = 7; k >= 0; k--) begin
        nb = int'((mem[x] >> (4 * k)) & 32'hF);
        exp_byte.push_back(nb < 10 ? 8'(48 + nb) : 8'(65 + nb - 10));
      end
      exp_byte.push_back(8'h0D);
      exp_byte.push_back(8'h0A);
      x = x + 32'd4;
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input int n);
    @(posedge HCLK); #1;
    start = 1'b1; start_addr = a; word_count = CW'(n);
    @(posedge HCLK); #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input string nm, input logic [31:0] a, input int n, input logic exp_err);
    int dc, t;
    expect_dump(a, n);
    dc = done_cnt;
    pulse_start(a, n);
    chk({nm, "_busy"}, 32'(busy), 32'(1));
    chk({nm, "_err_clr"}, 32'(err), 32'(0));
    t = 0;
    while (done !== 1'b1 && t < n * 100 * BAUD + 200) begin
      @(negedge HCLK); t++;
    end
    chk({nm, "_done"}, 32'(done), 32'(1));
    @(negedge HCLK);
    chk({nm, "_done_1cyc"}, 32'(done), 32'(0));
    chk({nm, "_idle_busy"}, 32'(busy), 32'(0));
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    chk({nm, "_done_cnt"}, 32'(done_cnt - dc), 32'(1));
    chk({nm, "_left_addr"}, 32'(exp_addr.size()), 32'(0));
    chk({nm, "_left_bytes"}, 32'(exp_byte.size()), 32'(0));
  endtask

  always @(negedge HCLK) if (done === 1'b1) done_cnt++;

  // Slave: programmable address-phase and data-phase wait states.
  initial begin
    logic        dphase, derr;
    logic [31:0] daddr;
    int          acnt, dcnt;
    dphase = 1'b0; derr = 1'b0; daddr = '0; acnt = 0; dcnt = 0;
    bus.HREADY = 1'b1; bus.HRDATA = '0; bus.HRESP = 1'b0;
    forever begin
      @(posedge HCLK); #1;
      if (!HRESETn) begin
        dphase = 1'b0; acnt = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end else if (dphase) begin
        if (dcnt < dw_n) begin
          bus.HREADY = 1'b0; bus.HRESP = derr && (dcnt == dw_n - 1); dcnt++;
        end else begin
          bus.HREADY = 1'b1; bus.HRESP = derr;
          bus.HRDATA = mem.exists(daddr) ? mem[daddr] : 32'd0;
          dphase = 1'b0;
        end
      end else if (bus.dumper_HTRANS == 2'b10) begin
        bus.HRESP = 1'b0;
        if (acnt < aw_n) begin
          bus.HREADY = 1'b0; acnt++;
        end else begin
          bus.HREADY = 1'b1; acnt = 0; dphase = 1'b1; dcnt = 0;
          daddr = bus.dumper_HADDR; derr = err_en && (bus.dumper_HADDR == err_addr);
        end
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end
    end
  end

  // Bus monitor: accepted NONSEQ reads against the expected address queue.
  initial begin
    logic        pend;
    logic [31:0] pa;
    pend = 1'b0; pa = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("hold_trans", 32'(bus.dumper_HTRANS), 32'(2'b10));
          chk("hold_addr", bus.dumper_HADDR, pa);
        end
        pend = 1'b0;
        if (bus.dumper_HTRANS == 2'b10) begin
          if (!bus.HREADY) begin
            pend = 1'b1; pa = bus.dumper_HADDR;
          end else if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL read_unexpected: got read at %h expected none", bus.dumper_HADDR);
          end else begin
            chk("read_addr", bus.dumper_HADDR, exp_addr.pop_front());
            chk("ahb_ctrl", 32'({bus.dumper_HBURST, bus.dumper_HMASTLOCK, bus.dumper_HPROT,
                                 bus.dumper_HSIZE, bus.dumper_HWRITE, bus.dumper_HWDATA == 32'd0}),
                32'({3'b000, 1'b0, 4'b0011, 3'b010, 1'b0, 1'b1}));
          end
        end
      end
    end
  end

  // UART monitor: mid-bit sampling; frames cut by reset are discarded.
  initial begin
    logic [7:0] b;
    logic       ok, stp;
    b = '0; ok = 1'b0; stp = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESETn && UART_TX === 1'b0) begin
        ok = 1'b1;
        repeat (BAUD / 2) begin @(negedge HCLK); if (!HRESETn) ok = 1'b0; end
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) begin @(negedge HCLK); if (!HRESETn) ok = 1'b0; end
          b[i] = UART_TX;
        end
        repeat (BAUD) begin @(negedge HCLK); if (!HRESETn) ok = 1'b0; end
        stp = UART_TX;
        if (ok) begin
          if (exp_byte.size() == 0) begin
            checks++; errors++;
            $display("FAIL uart_unexpected: got byte %h expected none", b);
          end else begin
            chk("uart_byte", 32'(b), 32'(exp_byte.pop_front()));
            chk("uart_stop", 32'(stp), 32'(1));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int dc, n;
    logic [31:0] a;
    #2 HRESETn = 1'b0;
    repeat (3) @(posedge HCLK); #1;
    chk("rst_tx", 32'(UART_TX), 32'(1));
    chk("rst_htrans", 32'(bus.dumper_HTRANS), 32'(0));
    chk("rst_haddr", bus.dumper_HADDR, 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);

    mem[32'h100] = 32'h1234ABCD;
    run_dump("t1", 32'h100, 1, 1'b0);

    aw_n = 2; dw_n = 2;
    run_dump("t2", 32'h200, 3, 1'b0);

    aw_n = 1; dw_n = 1;
    run_dump("t3", 32'hFFFF_FFFE, 2, 1'b0);

    // Zero-length dump: Done in the cycle after start, nothing on bus or line.
    dc = done_cnt;
    pulse_start(32'h300, 0);
    chk("t4_done", 32'(done), 32'(1));
    chk("t4_busy", 32'(busy), 32'(0));
    chk("t4_htrans", 32'(bus.dumper_HTRANS), 32'(0));
    repeat (30) @(negedge HCLK);
    chk("t4_done_cnt", 32'(done_cnt - dc), 32'(1));
    chk("t4_tx", 32'(UART_TX), 32'(1));

    aw_n = 0; dw_n = 1; err_en = 1'b1; err_addr = 32'h400;
    run_dump("t5", 32'h400, 2, 1'b1);
    err_en = 1'b0;
    run_dump("t5b", 32'h500, 1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      n = int'($urandom_range(1, 3));
      aw_n = int'($urandom_range(0, 2));
      dw_n = int'($urandom_range(0, 3));
      run_dump("rnd", a, n, 1'b0);
    end

    // Start while busy is ignored; reset mid-byte of the second word aborts.
    aw_n = 0; dw_n = 0;
    expect_dump(32'h600, 2);
    pulse_start(32'h600, 2);
    repeat (50) @(posedge HCLK);
    pulse_start(32'h7000, 1);
    chk("t6_busy", 32'(busy), 32'(1));
    repeat (100 * BAUD + 10) @(posedge HCLK);
    chk("t6_reads", 32'(exp_addr.size()), 32'(0));
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("t6_tx", 32'(UART_TX), 32'(1));
    chk("t6_rbusy", 32'(busy), 32'(0));
    chk("t6_htrans", 32'(bus.dumper_HTRANS), 32'(0));
    exp_byte.delete();
    exp_addr.delete();
    repeat (3) @(posedge HCLK);
    HRESETn = 1'b1;
    repeat (30 * BAUD) @(negedge HCLK);
    chk("t6_idle_tx", 32'(UART_TX), 32'(1));
    chk("t6_idle_busy", 32'(busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
